cache_assoc_ctrl: RTL and testbench

- Parametrised write-back, write-allocate cache controller for the memory stage. Supports 1- or 2-way set-associative arrays, a configurable line length and a configurable memory read latency.
- Sits between the CPU port (Rd/Wr/Addr/DataIn) and the per-way tag/data arrays plus the banked main memory.
- Adds two things the direct-mapped controller lacks: victim-way selection and a memory back-pressure handshake (mem_stall).
- Keeps saturating hit/miss statistics counters.

---
 rtl/cache_assoc_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_assoc_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_ctrl.sv
// Write-back, write-allocate cache controller for 1- or 2-way arrays with victim selection,
// memory back-pressure on commands and saturating hit/miss counters.
module cache_assoc_ctrl #(
  parameter int unsigned WAYS    = 2,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned WW = $clog2(WORDS),
  localparam int unsigned OW = WW + 1,
  localparam int unsigned IW = 13 - WW,
  localparam int unsigned TW = 16 - IW - OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rd,
  input  logic                 Wr,
  input  logic [15:0]          Addr,
  input  logic [15:0]          DataIn,
  output logic [15:0]          DataOut,
  output logic                 Done,
  output logic                 Stall,
  output logic                 CacheHit,
  output logic                 Err,
  output logic [WAYS-1:0]      cache_enable,
  output logic                 cache_comp,
  output logic                 cache_wr,
  output logic                 cache_valid_in,
  output logic [TW-1:0]        cache_tag_in,
  output logic [IW-1:0]        cache_index,
  output logic [OW-1:0]        cache_offset,
  output logic [15:0]          cache_data_in,
  input  logic [WAYS-1:0]      cache_hit,
  input  logic [WAYS-1:0]      cache_valid,
  input  logic [WAYS-1:0]      cache_dirty,
  input  logic [WAYS*TW-1:0]   cache_tag_out,
  input  logic [WAYS*16-1:0]   cache_data_out,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_data_in,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic                 mem_stall,
  input  logic [15:0]          mem_DataOut,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCompare = 3'd1;
  localparam logic [2:0] StWb      = 3'd2;
  localparam logic [2:0] StFill    = 3'd3;
  localparam logic [2:0] StRetry   = 3'd4;

  localparam logic [WW:0]   IssEnd   = (WW+1)'(WORDS);
  localparam logic [WW:0]   IssLast  = (WW+1)'(WORDS - 1);
  localparam logic [WW-1:0] WordLast = WW'(WORDS - 1);

  logic [2:0]         state_q, state_d;
  logic [15:0]        addr_q, din_q;
  logic               wr_q;
  logic               vic_q, vic_d, ptr_q, ptr_d, vic_sel;
  logic [WW:0]        iss_q, iss_d;
  logic [WW-1:0]      ret_q, ret_d;
  logic [MEM_LAT-1:0] tok_q, tok_d;
  logic [MEM_LAT:0]   tok_ext;
  logic               err_q, err_d;
  logic               issue, ret, hit_inc, miss_inc;
  logic [WAYS-1:0]    hv, vic_oh;
  logic               any_hit, multi_hit, hit_way;
  logic [15:0]        data_hit, data_vic;
  logic [TW-1:0]      tag, tag_vic;
  logic [IW-1:0]      idx;

  assign tag       = addr_q[15 -: TW];
  assign idx       = addr_q[OW +: IW];
  assign hv        = cache_hit & cache_valid;
  assign any_hit   = |hv;
  assign multi_hit = (WAYS > 1) && (&hv);
  // Multiple hits resolve to way 0.
  assign hit_way   = (WAYS > 1) && !hv[0];
  assign data_hit  = 16'(cache_data_out >> {hit_way, 4'b0});
  assign data_vic  = 16'(cache_data_out >> {vic_q, 4'b0});
  assign tag_vic   = TW'(cache_tag_out >> (TW * 32'(vic_q)));
  assign vic_oh    = WAYS'(1) << vic_q;
  assign ret       = tok_q[MEM_LAT-1];
  assign Stall     = (state_q != StIdle);
  assign cache_tag_in = tag;
  assign cache_index  = idx;

  always_comb begin
    if (!cache_valid[0])                          vic_sel = 1'b0;
    else if ((WAYS > 1) && !cache_valid[WAYS-1])  vic_sel = 1'b1;
    else                                          vic_sel = ptr_q;
  end

  always_comb begin
    state_d = state_q;
    vic_d = vic_q;
    ptr_d = ptr_q;
    iss_d = iss_q;
    ret_d = ret_q;
    err_d = 1'b0;
    issue = 1'b0;
    hit_inc = 1'b0;
    miss_inc = 1'b0;
    Done = 1'b0;
    CacheHit = 1'b0;
    Err = err_q;
    DataOut = '0;
    cache_enable = '0;
    cache_comp = 1'b0;
    cache_wr = 1'b0;
    cache_valid_in = 1'b0;
    cache_offset = addr_q[OW-1:0];
    cache_data_in = din_q;
    mem_addr = '0;
    mem_data_in = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (state_q)
      StIdle: begin
        if (Rd || Wr) begin
          if ((Rd && Wr) || Addr[0]) err_d = 1'b1;
          else                       state_d = StCompare;
        end
      end
      StCompare: begin
        cache_enable = '1;
        cache_comp = 1'b1;
        cache_wr = wr_q;
        if (any_hit) begin
          Done = 1'b1;
          CacheHit = 1'b1;
          DataOut = data_hit;
          hit_inc = 1'b1;
          Err = multi_hit;
          state_d = StIdle;
        end else begin
          miss_inc = 1'b1;
          vic_d = vic_sel;
          iss_d = '0;
          ret_d = '0;
          if ((WAYS > 1) && cache_valid[vic_sel]) ptr_d = ~ptr_q;
          state_d = (cache_valid[vic_sel] && cache_dirty[vic_sel]) ? StWb : StFill;
        end
      end
      StWb: begin
        cache_enable = vic_oh;
        cache_offset = {iss_q[WW-1:0], 1'b0};
        mem_wr = 1'b1;
        mem_addr = {tag_vic, idx, iss_q[WW-1:0], 1'b0};
        mem_data_in = data_vic;
        if (!mem_stall) begin
          if (iss_q == IssLast) begin
            iss_d = '0;
            state_d = StFill;
          end else begin
            iss_d = iss_q + 1'b1;
          end
        end
      end
      StFill: begin
        if (iss_q < IssEnd) begin
          mem_rd = 1'b1;
          mem_addr = {tag, idx, iss_q[WW-1:0], 1'b0};
          if (!mem_stall) begin
            issue = 1'b1;
            iss_d = iss_q + 1'b1;
          end
        end
        // Returns are token-timed and ignore back-pressure.
        if (ret) begin
          cache_enable = vic_oh;
          cache_wr = 1'b1;
          cache_valid_in = 1'b1;
          cache_offset = {ret_q, 1'b0};
          cache_data_in = mem_DataOut;
          ret_d = ret_q + 1'b1;
          if (ret_q == WordLast) state_d = StRetry;
        end
      end
      StRetry: begin
        cache_enable = vic_oh;
        cache_comp = 1'b1;
        cache_wr = wr_q;
        Done = 1'b1;
        DataOut = data_vic;
        state_d = StIdle;
      end
      default: begin
        Err = 1'b1;
        state_d = StIdle;
      end
    endcase
    tok_ext = {tok_q, issue};
    tok_d = (state_q == StFill) ? tok_ext[MEM_LAT-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      vic_q    <= 1'b0;
      ptr_q    <= 1'b0;
      iss_q    <= '0;
      ret_q    <= '0;
      tok_q    <= '0;
      err_q    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
      ptr_q   <= ptr_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      tok_q   <= tok_d;
      err_q   <= err_d;
      if (!Stall) begin
        addr_q <= Addr;
        din_q  <= DataIn;
        wr_q   <= Wr;
      end
      if (hit_inc && !(&hit_cnt))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Scoreboard bench for cache_assoc_ctrl: behavioural 2-way tag/data arrays and a latency-2
// banked memory with programmable back-pressure; Done results checked against a flat golden memory.
module tb_cache_assoc_ctrl;

  localparam int unsigned MEM_LAT = 2;

  logic        clk, rst, Rd, Wr;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Done, Stall, CacheHit, Err;
  logic [1:0]  cache_enable;
  logic        cache_comp, cache_wr, cache_valid_in;
  logic [1:0]  cache_tag_in;
  logic [10:0] cache_index;
  logic [2:0]  cache_offset;
  logic [15:0] cache_data_in;
  logic [1:0]  cache_hit, cache_valid, cache_dirty;
  logic [3:0]  cache_tag_out;
  logic [31:0] cache_data_out;
  logic [15:0] mem_addr, mem_data_in, mem_DataOut;
  logic        mem_rd, mem_wr, mem_stall;
  logic [15:0] hit_cnt, miss_cnt;

  cache_assoc_ctrl #(.WAYS(2), .WORDS(4), .MEM_LAT(MEM_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err),
    .cache_enable(cache_enable), .cache_comp(cache_comp), .cache_wr(cache_wr),
    .cache_valid_in(cache_valid_in), .cache_tag_in(cache_tag_in), .cache_index(cache_index),
    .cache_offset(cache_offset), .cache_data_in(cache_data_in), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag_out(cache_tag_out),
    .cache_data_out(cache_data_out), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_stall(mem_stall), .mem_DataOut(mem_DataOut),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic        rd;
    logic [15:0] data;
    logic        hit;
    logic [7:0]  lat;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] rd_log[$];
  logic [31:0] wr_log[$];
  int          n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0, stall_left = 0, req_id = 0;

  logic [15:0] mem  [32768];
  logic [15:0] gold [32768];
  logic [15:0] rpipe [MEM_LAT];
  logic [15:0] arr_data [2][2048][4];
  logic [1:0]  arr_tag  [2][2048];
  logic        arr_v    [2][2048];
  logic        arr_d    [2][2048];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 263) ^ 16'h3C5A;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Tag/data arrays: combinational lookup, writes on the clock edge.
  always_comb begin
    cache_hit = '0;
    cache_valid = '0;
    cache_dirty = '0;
    cache_tag_out = '0;
    cache_data_out = '0;
    for (int w = 0; w < 2; w++) begin
      cache_valid[w] = arr_v[w][cache_index];
      cache_dirty[w] = arr_d[w][cache_index];
      cache_tag_out[w*2 +: 2] = arr_tag[w][cache_index];
      cache_data_out[w*16 +: 16] = arr_data[w][cache_index][cache_offset[2:1]];
      cache_hit[w] = cache_enable[w] && cache_comp && (arr_tag[w][cache_index] == cache_tag_in);
    end
  end

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (cache_enable[w] && cache_wr) begin
        if (cache_comp) begin
          if (arr_v[w][cache_index] && arr_tag[w][cache_index] == cache_tag_in) begin
            arr_data[w][cache_index][cache_offset[2:1]] <= cache_data_in;
            arr_d[w][cache_index] <= 1'b1;
          end
        end else begin
          arr_data[w][cache_index][cache_offset[2:1]] <= cache_data_in;
          arr_tag[w][cache_index] <= cache_tag_in;
          arr_v[w][cache_index] <= cache_valid_in;
          arr_d[w][cache_index] <= 1'b0;
        end
      end
    end
  end

  // Memory: commands accepted only when mem_stall is low; read data MEM_LAT cycles later.
  always @(posedge clk) begin
    if (mem_wr && !mem_stall) begin
      mem[mem_addr[15:1]] <= mem_data_in;
      wr_log.push_back({mem_addr, mem_data_in});
    end
    if (mem_rd && !mem_stall) rd_log.push_back(mem_addr);
    rpipe[0] <= (mem_rd && !mem_stall) ? mem[mem_addr[15:1]] : 16'hDEAD;
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_DataOut = rpipe[MEM_LAT-1];

  // Back-pressure: hold off FILL word 1 of line 0x2020 for stall_left cycles.
  initial begin
    logic held;
    held = 0;
    mem_stall = 0;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && mem_rd && mem_addr == 16'h2022) begin
        mem_stall = 1;
        stall_left--;
        held = 1;
      end else begin
        if (held) check("stall_hold_addr", mem_addr, 16'h2022);
        held = 0;
        mem_stall = 0;
      end
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst && Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 1);
      end else begin
        sb_t it;
        it = sb.pop_front();
        check($sformatf("req%0d_hit", it.id), CacheHit, it.hit);
        check($sformatf("req%0d_lat", it.id), 32'(cyc - acc_cyc + 1), it.lat);
        if (it.rd) check($sformatf("req%0d_data", it.id), DataOut, it.data);
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic exp_hit, input int exp_lat);
    sb_t it;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    it.id = 8'(req_id);
    it.rd = rd;
    it.data = gold[a[15:1]];
    it.hit = exp_hit;
    it.lat = 8'(exp_lat);
    req_id++;
    if (wr) gold[a[15:1]] = d;
    sb.push_back(it);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    Rd = 0; Wr = 0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("done_pending", 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic err_req(input logic rd, input logic wr, input logic [15:0] a);
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = a;
    @(posedge clk);
    #1;
    Rd = 0; Wr = 0;
    @(negedge clk);
    check("err_pulse", Err, 1);
    check("err_nostall", Stall, 0);
    @(negedge clk);
    check("err_clear", Err, 0);
  endtask

  initial begin
    logic found;
    rst = 0; Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = init_word(i);
      gold[i] = init_word(i);
    end
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 2048; j++) begin
        arr_v[w][j] = 0; arr_d[w][j] = 0; arr_tag[w][j] = 0;
        for (int k = 0; k < 4; k++) arr_data[w][j][k] = 0;
      end
    for (int i = 0; i < MEM_LAT; i++) rpipe[i] = 16'hDEAD;

    repeat (2) @(negedge clk);
    check("rst_done", Done, 0);
    check("rst_stall", Stall, 0);
    check("rst_err", Err, 0);
    check("rst_memcmd", {mem_rd, mem_wr}, 0);
    check("rst_enable", cache_enable, 0);
    check("rst_dataout", DataOut, 0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 0);
    rst = 1;

    // Clean miss with both ways invalid, then hit.
    rd_log.delete();
    do_req(1, 0, 16'h0010, 0, 0, 8);
    check("fill_cnt", 32'(rd_log.size()), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      check($sformatf("fill_addr%0d", k), rd_log[k], 16'h0010 + 16'(2*k));
    check("miss_cnt1", miss_cnt, 1);
    do_req(1, 0, 16'h0010, 0, 1, 1);
    check("hit_cnt1", hit_cnt, 1);

    // Dirty lines in both ways of index 2, then evict each in pointer order.
    do_req(0, 1, 16'h4010, 16'hBEEF, 0, 8);
    do_req(0, 1, 16'h0012, 16'h1357, 1, 1);
    wr_log.delete();
    do_req(1, 0, 16'hC014, 0, 0, 12);
    check("wb0_cnt", 32'(wr_log.size()), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      check($sformatf("wb0_addr%0d", k), wr_log[k][31:16], 16'h0010 + 16'(2*k));
      check($sformatf("wb0_data%0d", k), wr_log[k][15:0], gold[(16'h0010 + 2*k) >> 1]);
    end
    wr_log.delete();
    do_req(1, 0, 16'h8016, 0, 0, 12);
    check("wb1_cnt", 32'(wr_log.size()), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++)
      check($sformatf("wb1_addr%0d", k), wr_log[k][31:16], 16'h4010 + 16'(2*k));
    do_req(1, 0, 16'h0012, 0, 0, 8);
    check("miss_cnt5", miss_cnt, 5);

    // Back-pressure on FILL word 1 for three cycles.
    rd_log.delete();
    stall_left = 3;
    do_req(1, 0, 16'h2020, 0, 0, 11);
    check("stall_fill_cnt", 32'(rd_log.size()), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      check($sformatf("stall_addr%0d", k), rd_log[k], 16'h2020 + 16'(2*k));
    do_req(1, 0, 16'h2026, 0, 1, 1);

    // Illegal requests.
    rd_log.delete();
    wr_log.delete();
    err_req(1, 1, 16'h0010);
    err_req(0, 1, 16'h0011);
    check("err_no_mem", 32'(rd_log.size() + wr_log.size()), 0);
    check("err_miss_cnt", miss_cnt, 6);

    // Reset in the middle of a write-back.
    do_req(0, 1, 16'h0100, 16'hA5A5, 0, 8);
    do_req(0, 1, 16'h4100, 16'h5A5A, 0, 8);
    wr_log.delete();
    @(negedge clk);
    Rd = 1; Addr = 16'h8100;
    @(posedge clk);
    #1;
    Rd = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_wr && mem_addr[2:0] == 3'h4) found = 1;
    end
    check("wb_word2_seen", found, 1);
    rst = 0;
    #1;
    check("mid_rst_done_stall", {Done, Stall, Err, CacheHit}, 0);
    check("mid_rst_mem", {mem_rd, mem_wr}, 0);
    check("mid_rst_enable", {cache_enable, cache_wr, cache_comp}, 0);
    check("mid_rst_cnts", {hit_cnt, miss_cnt}, 0);
    check("mid_rst_wb_words", 32'(wr_log.size()), 2);
    @(negedge clk);
    rst = 1;
    do_req(1, 0, 16'h0104, 0, 1, 1);
    check("post_rst_hit_cnt", hit_cnt, 1);
    check("post_rst_miss_cnt", miss_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule
